// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: two-requester round-robin arbiter in front of a simple
// GPIO peripheral (IN / OUT / DIR registers) on a shared tri-state data bus.
// Each transaction walks IDLE -> ADDR -> STROBE -> DONE (illegal op skips
// STROBE). All outputs come straight from flops loaded with their next-cycle
// value, so they line up with the state they belong to.
module gpio_bus_arbiter #(
   parameter logic [7:0] ADDRESS_IN   = 8'b00000100,
   parameter logic [7:0] ADDRESS_OUT  = 8'b00000101,
   parameter logic [7:0] ADDRESS_DIR  = 8'b00000110,
   parameter logic [7:0] ADDRESS_IDLE = 8'b00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [1:0]  op0,
   input  logic [1:0]  op1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [15:0] rdata,
   output logic        busy,
   output logic [7:0]  addressbus,
   inout  wire  [15:0] databus,
   output logic        Read_In,
   output logic        Load_Out,
   output logic        Load_DIR
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned OP_W   = 2;

   localparam logic [OP_W-1:0] OP_RD   = 2'b00;
   localparam logic [OP_W-1:0] OP_WOUT = 2'b01;
   localparam logic [OP_W-1:0] OP_WDIR = 2'b10;
   localparam logic [OP_W-1:0] OP_ILL  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ADDR   = 2'd1,
      S_STROBE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                ptr_q, ptr_d;
   logic                win_q, win_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                done0_q, done0_d, done1_q, done1_d;
   logic                err0_q, err0_d, err1_q, err1_d;
   logic                busy_q, busy_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rd_in_q, rd_in_d;
   logic                ld_out_q, ld_out_d;
   logic                ld_dir_q, ld_dir_d;
   logic                drive_q, drive_d;
   logic                bus_phase;

   // Next state, arbitration, transaction latch and read capture
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      op_d    = op_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // tie goes to the preferred requester, a sole requester always wins
               win_d   = (req0 && req1) ? ptr_q : req1;
               op_d    = win_d ? op1 : op0;
               wdata_d = win_d ? wdata1 : wdata0;
               ptr_d   = ~win_d;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            state_d = (op_q == OP_ILL) ? S_DONE : S_STROBE;
         end
         S_STROBE: begin
            if (op_q == OP_RD) begin
               rdata_d = databus;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output values for the cycle following the next edge, decoded from next state
   always_comb begin
      bus_phase = (state_d == S_ADDR) || (state_d == S_STROBE);
      busy_d    = (state_d != S_IDLE);
      gnt0_d    = busy_d && !win_d;
      gnt1_d    = busy_d && win_d;
      done0_d   = (state_d == S_DONE) && !win_d;
      done1_d   = (state_d == S_DONE) && win_d;
      err0_d    = done0_d && (op_d == OP_ILL);
      err1_d    = done1_d && (op_d == OP_ILL);
      rd_in_d   = (state_d == S_STROBE) && (op_d == OP_RD);
      ld_out_d  = (state_d == S_STROBE) && (op_d == OP_WOUT);
      ld_dir_d  = (state_d == S_STROBE) && (op_d == OP_WDIR);
      drive_d   = bus_phase && ((op_d == OP_WOUT) || (op_d == OP_WDIR));
      addr_d    = ADDRESS_IDLE;
      if (bus_phase) begin
         case (op_d)
            OP_RD:   addr_d = ADDRESS_IN;
            OP_WOUT: addr_d = ADDRESS_OUT;
            OP_WDIR: addr_d = ADDRESS_DIR;
            default: addr_d = ADDRESS_IDLE;
         endcase
      end
   end

   // State and output registers; reset aborts any transaction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ptr_q    <= 1'b0;
         win_q    <= 1'b0;
         op_q     <= OP_RD;
         wdata_q  <= '0;
         rdata_q  <= '0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         busy_q   <= 1'b0;
         addr_q   <= ADDRESS_IDLE;
         rd_in_q  <= 1'b0;
         ld_out_q <= 1'b0;
         ld_dir_q <= 1'b0;
         drive_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         op_q     <= op_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         busy_q   <= busy_d;
         addr_q   <= addr_d;
         rd_in_q  <= rd_in_d;
         ld_out_q <= ld_out_d;
         ld_dir_q <= ld_dir_d;
         drive_q  <= drive_d;
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign done0      = done0_q;
   assign done1      = done1_q;
   assign err0       = err0_q;
   assign err1       = err1_q;
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign addressbus = addr_q;
   assign Read_In    = rd_in_q;
   assign Load_Out   = ld_out_q;
   assign Load_DIR   = ld_dir_q;

   // Write data goes on the shared bus only during ADDR/STROBE of a write
   assign databus = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: GPIO peripheral model on the bus, a transaction
// level reference model feeding a scoreboard, a negedge monitor, directed
// scenarios and a randomized phase.
module tb_gpio_bus_arbiter;

   localparam logic [7:0] A_IN   = 8'h04;
   localparam logic [7:0] A_OUT  = 8'h05;
   localparam logic [7:0] A_DIR  = 8'h06;
   localparam logic [7:0] A_IDLE = 8'h00;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [1:0]  op0 = 2'b00, op1 = 2'b00;
   logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0;
   logic        gnt0, gnt1, done0, done1, err0, err1, busy;
   logic [15:0] rdata;
   logic [7:0]  addressbus;
   logic        Read_In, Load_Out, Load_DIR;
   wire  [15:0] databus;

   logic [15:0] per_out = 16'h0, per_dir = 16'h0, io_pins = 16'h0;
   logic [15:0] bus_s;

   int n_checks = 0;
   int n_err    = 0;

   gpio_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .rdata(rdata), .busy(busy),
      .addressbus(addressbus), .databus(databus),
      .Read_In(Read_In), .Load_Out(Load_Out), .Load_DIR(Load_DIR)
   );

   always #5 clk = ~clk;

   // Peripheral: pins read through DIR mask, OUT/DIR loaded on their strobes
   assign databus = Read_In ? ((io_pins & ~per_dir) | (per_out & per_dir)) : 16'hzzzz;

   always_comb begin
      for (int i = 0; i < 16; i++) bus_s[i] = (databus[i] === 1'b1);
   end

   always @(posedge clk) begin
      if (Load_Out) per_out <= bus_s;
      if (Load_DIR) per_dir <= bus_s;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      logic        win;
      logic [1:0]  op;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          done_edge;
   } exp_t;

   exp_t        sb[$];
   exp_t        m_e;
   int          edge_n    = 0;
   int          free_edge = 0;
   logic        ptr_m     = 1'b0;
   logic [15:0] out_m = 16'h0, dir_m = 16'h0, last_rd = 16'h0, rd_val;
   logic        pend_v = 1'b0;
   int          pend_edge = 0;
   logic [1:0]  pend_op = 2'b00;
   logic [15:0] pend_data = 16'h0;

   // A transaction occupies the bus for a fixed number of edges; its effect
   // on the peripheral lands at the edge ending STROBE (acceptance + 2).
   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         sb.delete();
         free_edge = edge_n;
         ptr_m     = 1'b0;
         pend_v    = 1'b0;
         last_rd   = 16'h0;
      end else begin
         if (pend_v && edge_n == pend_edge) begin
            case (pend_op)
               2'b00:   last_rd = pend_data;
               2'b01:   out_m   = pend_data;
               default: dir_m   = pend_data;
            endcase
            pend_v = 1'b0;
         end
         if (edge_n >= free_edge && (req0 || req1)) begin
            m_e.win   = (req0 && req1) ? ptr_m : req1;
            ptr_m     = ~m_e.win;
            m_e.op    = m_e.win ? op1 : op0;
            m_e.wdata = m_e.win ? wdata1 : wdata0;
            rd_val    = (io_pins & ~dir_m) | (out_m & dir_m);
            m_e.rdata = (m_e.op == 2'b00) ? rd_val : last_rd;
            m_e.done_edge = edge_n + ((m_e.op == 2'b11) ? 2 : 3);
            free_edge     = edge_n + ((m_e.op == 2'b11) ? 3 : 4);
            if (m_e.op != 2'b11) begin
               pend_v    = 1'b1;
               pend_edge = edge_n + 2;
               pend_op   = m_e.op;
               pend_data = (m_e.op == 2'b00) ? rd_val : m_e.wdata;
            end
            sb.push_back(m_e);
         end
         edge_n++;
      end
   end

   // ---------------- monitor ----------------
   exp_t        mon_e;
   logic        prev_strobe = 1'b0;
   logic [5:0]  ctrl_exp;
   logic [7:0]  strobe_addr;
   logic        obs_win[$];
   int          obs_edge[$];

   initial forever begin
      @(negedge clk);
      if (reset) begin
         prev_strobe = 1'b0;
      end else begin
         if (done0 || done1) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'({done1, done0}), 32'h0);
            end else begin
               mon_e = sb.pop_front();
               obs_win.push_back(done1);
               obs_edge.push_back(edge_n);
               ctrl_exp = mon_e.win ? {2'b10, 2'b10, (mon_e.op == 2'b11), 1'b0}
                                    : {2'b01, 2'b01, 1'b0, (mon_e.op == 2'b11)};
               chk("done_latency", 32'(edge_n), 32'(mon_e.done_edge));
               chk("gnt_done_err", 32'({gnt1, gnt0, done1, done0, err1, err0}), 32'(ctrl_exp));
               chk("rdata", 32'(rdata), 32'(mon_e.rdata));
               if (mon_e.op == 2'b01) chk("per_out", 32'(per_out), 32'(mon_e.wdata));
               if (mon_e.op == 2'b10) chk("per_dir", 32'(per_dir), 32'(mon_e.wdata));
            end
         end
         if (Read_In || Load_Out || Load_DIR) begin
            strobe_addr = Read_In ? A_IN : (Load_Out ? A_OUT : A_DIR);
            chk("strobe_onehot", 32'(int'(Read_In) + int'(Load_Out) + int'(Load_DIR)), 32'd1);
            chk("strobe_addr", 32'(addressbus), 32'(strobe_addr));
            chk("strobe_len", 32'(prev_strobe), 32'd0);
         end
         prev_strobe = Read_In || Load_Out || Load_DIR;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drop_reqs();
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      drop_reqs();
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic issue(input logic who, input logic [1:0] op, input logic [15:0] data);
      @(negedge clk);
      if (who) begin req1 = 1'b1; op1 = op; wdata1 = data; end
      else     begin req0 = 1'b1; op0 = op; wdata0 = data; end
      @(negedge clk);
      drop_reqs();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ctrl"}, 32'({gnt0, gnt1, done0, done1, err0, err1, busy,
                               Read_In, Load_Out, Load_DIR}), 32'h0);
      chk({tag, "_rdata"}, 32'(rdata), 32'h0);
      chk({tag, "_addr"}, 32'(addressbus), 32'(A_IDLE));
      chk({tag, "_bus"}, 32'(bus_s), 32'h0);
   endtask

   // ---------------- directed and random scenarios ----------------
   initial begin
      #12;
      chk_reset_state("reset");
      @(negedge clk);
      reset = 1'b0;

      // single write to OUT
      issue(1'b0, 2'b01, 16'hA5A5);
      chk("wr_addr_ADDR", 32'(addressbus), 32'(A_OUT));
      chk("wr_bus_ADDR", 32'(bus_s), 32'hA5A5);
      chk("wr_gnt", 32'({gnt1, gnt0, busy}), 32'b011);
      @(negedge clk);
      chk("wr_strobe", 32'({Read_In, Load_Out, Load_DIR}), 32'b010);
      chk("wr_bus_STROBE", 32'(bus_s), 32'hA5A5);
      @(negedge clk);
      chk("wr_done", 32'({Load_Out, done0}), 32'b01);
      chk("wr_bus_released", 32'(bus_s), 32'h0);
      chk("wr_per_out", 32'(per_out), 32'hA5A5);
      drain();

      // read with DIR = 0 and pins = 1234
      io_pins = 16'h1234;
      issue(1'b1, 2'b10, 16'h0000);
      drain();
      issue(1'b1, 2'b00, 16'hFFFF);
      chk("rd_addr_ADDR", 32'(addressbus), 32'(A_IN));
      chk("rd_bus_undriven", 32'(bus_s), 32'h0);
      @(negedge clk);
      chk("rd_strobe", 32'({Read_In, Load_Out, Load_DIR}), 32'b100);
      chk("rd_bus_STROBE", 32'(bus_s), 32'h1234);
      @(negedge clk);
      chk("rd_done1", 32'({done1, done0}), 32'b10);
      chk("rd_rdata", 32'(rdata), 32'h1234);
      drain();

      // illegal op
      issue(1'b0, 2'b11, 16'h5555);
      chk("ill_addr_ADDR", 32'(addressbus), 32'(A_IDLE));
      chk("ill_bus_ADDR", 32'(bus_s), 32'h0);
      @(negedge clk);
      chk("ill_done_err", 32'({done0, err0, Read_In, Load_Out, Load_DIR}), 32'b11000);
      chk("ill_addr_DONE", 32'(addressbus), 32'(A_IDLE));
      drain();

      // mid-transaction change of request and data
      issue(1'b0, 2'b01, 16'h1111);
      wdata0 = 16'h2222;
      op0    = 2'b10;
      drain();
      chk("chg_per_out", 32'(per_out), 32'h1111);

      // reset during STROBE of a DIR write
      issue(1'b0, 2'b10, 16'hBEEF);
      @(negedge clk);
      chk("rst_dir_strobe", 32'(Load_DIR), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk_reset_state("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_no_dir_load", 32'(per_dir), 32'h0000);
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1; op0 = 2'b01; op1 = 2'b01;
      @(negedge clk);
      drop_reqs();
      chk("rst_tie_gnt", 32'({gnt1, gnt0}), 32'b01);
      drain();

      // tie held from reset
      reset = 1'b1;
      req0 = 1'b1; req1 = 1'b1; op0 = 2'b01; op1 = 2'b01;
      wdata0 = 16'h0A0A; wdata1 = 16'h0B0B;
      @(negedge clk);
      chk_reset_state("tie_reset");
      obs_win.delete();
      obs_edge.delete();
      reset = 1'b0;
      repeat (13) @(negedge clk);
      drain();
      chk("tie_count", 32'(obs_win.size()), 32'd4);
      if (obs_win.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("tie_order", 32'(obs_win[i]), 32'(i % 2));
            if (i > 0) chk("tie_spacing", 32'(obs_edge[i] - obs_edge[i-1]), 32'd4);
         end
      end

      // randomized traffic
      io_pins = 16'($urandom);
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         req0   = ($urandom_range(0, 2) == 0);
         req1   = ($urandom_range(0, 2) == 0);
         op0    = 2'($urandom_range(0, 3));
         op1    = 2'($urandom_range(0, 3));
         wdata0 = 16'($urandom);
         wdata1 = 16'($urandom);
      end
      drain();
      chk("final_per_out", 32'(per_out), 32'(out_m));
      chk("final_per_dir", 32'(per_dir), 32'(dir_m));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_bus_arbiter.md
GPIO_BUS_ARBITER -- requirements
Module: gpio_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high, with ports named clk and reset.
REQ-002 Parameters SHALL be, one per line:
- ADDRESS_IN, default 8'b00000100, GPIO input register address.
- ADDRESS_OUT, default 8'b00000101, GPIO output register address.
- ADDRESS_DIR, default 8'b00000110, GPIO direction register address.
- ADDRESS_IDLE, default 8'b00000000, address driven when no transaction is active.
REQ-003 Ports SHALL be, one per line:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-high reset.
- req0, req1  input  1 each  transaction request from requester 0 / 1.
- op0, op1  input  2 each  operation: 00 = read IN, 01 = write OUT, 10 = write DIR, 11 = illegal.
- wdata0, wdata1  input  16 each  write data.
- gnt0, gnt1  output  1 each  requester owns the peripheral bus.
- done0, done1  output  1 each  one-cycle completion pulse.
- err0, err1  output  1 each  one-cycle illegal-op pulse, coincident with done.
- rdata  output  16  last read result, shared by both requesters.
- busy  output  1  high whenever state is not IDLE.
- addressbus  output  8  peripheral address.
- databus  inout  16  peripheral data bus.
- Read_In, Load_Out, Load_DIR  output  1 each  peripheral strobes.

Function
REQ-004 The FSM SHALL have the states IDLE, ADDR, STROBE and DONE.
REQ-005 In IDLE, if any request is high at a rising edge, the FSM SHALL latch the winner's index, op and wdata, then move to ADDR; otherwise it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin with a 1-bit priority pointer (reset 0 = requester 0 preferred):
- A sole requester always wins.
- On a tie, the preferred requester wins.
- After each grant, the pointer moves to the other requester.
REQ-007 ADDR SHALL always go to STROBE for ops 00/01/10, and to DONE for op 11.
REQ-008 STROBE SHALL always go to DONE, and DONE SHALL always go to IDLE; there are no wait states.
REQ-009 gntN SHALL be high in ADDR, STROBE and DONE for the latched winner only.
REQ-010 In ADDR and STROBE, addressbus SHALL carry the parameter address matching the latched op; in IDLE and DONE, and for op 11, it SHALL carry ADDRESS_IDLE.
REQ-011 The strobe SHALL be high only during STROBE, exactly one cycle:
- op 00 → Read_In
- op 01 → Load_Out
- op 10 → Load_DIR
- At most one strobe is ever high.
REQ-012 For write ops, the block SHALL drive the latched wdata onto databus in ADDR and STROBE; in all other states and for all other ops, databus SHALL be high-Z.
REQ-013 For op 00, the block SHALL capture databus into rdata at the rising edge that ends STROBE; rdata SHALL hold until the next read.
REQ-014 doneN SHALL pulse high for one cycle in DONE for the latched winner; errN SHALL pulse alongside it for op 11.
REQ-015 Latency: with a request sampled at edge k, done SHALL be high in the cycle after edge k+2 (op 11: after edge k+1), and rdata SHALL be valid in that same cycle.
REQ-016 Request inputs SHALL be ignored outside IDLE; deasserting a request or changing op/wdata mid-transaction SHALL NOT alter the transaction in flight.
REQ-017 A request still high when the FSM returns to IDLE SHALL start a new arbitration; back-to-back throughput is therefore one transaction per 4 cycles (3 cycles for op 11).
REQ-018 Requests arriving in ADDR, STROBE or DONE SHALL NOT be queued; they win only if still high in IDLE.

Reset
REQ-019 Reset SHALL immediately force the following, even mid-transaction, with no completion or done pulse:
- state = IDLE, priority pointer = 0
- gnt, done, err, busy, strobes = 0
- rdata = 16'h0000
- addressbus = ADDRESS_IDLE
- databus = high-Z
REQ-020 After reset deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single write: req0, op0=01, wdata0=16'hA5A5 → address 8'h05 in ADDR and STROBE; Load_Out high exactly 1 cycle with databus=16'hA5A5; done0 pulses; peripheral OUT register = 16'hA5A5.
- Read after DIR=16'h0000 and IO=16'h1234: req1, op1=00 → Read_In high 1 cycle at address 8'h04; rdata=16'h1234 when done1 pulses; databus never driven by the arbiter.
- Tie: req0 and req1 held high from reset with writes → grant order 0,1,0,1; each done exactly 4 cycles apart.
- Illegal op: op0=11 → no strobe; address stays ADDRESS_IDLE; done0 and err0 pulse together 2 cycles after the request is sampled.
- Reset mid-op: assert reset during STROBE of a DIR write → Load_DIR drops asynchronously, databus goes Z, no done pulse, pointer returns to 0; the next tie grants requester 0.
- Mid-transaction change: drop req0 and change wdata0 in ADDR → the originally latched data is written and done0 still pulses.
